// File: rtl/mult_2x1_arb_if.sv
// Handshake bundle between requesters, the arbiter, the shared multiplier and the response consumer.
// slave = arbiter view; master = environment view (requesters, multiplier, consumer).
// req_lock only exists when MULT_ARB_LOCK_EN is defined.
interface mult_2x1_arb_if #(
  parameter int BIT_NUM = 18,
  parameter int NREQ    = 4,
  parameter int ID_W    = 2
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*BIT_NUM-1:0] req_a00;
  logic [NREQ*BIT_NUM-1:0] req_a10;
  logic [NREQ*BIT_NUM-1:0] req_b;
`ifdef MULT_ARB_LOCK_EN
  logic [NREQ-1:0]         req_lock;
`endif
  logic [BIT_NUM-1:0]      mul_a00;
  logic [BIT_NUM-1:0]      mul_a10;
  logic [BIT_NUM-1:0]      mul_b;
  logic [BIT_NUM-1:0]      mul_c00;
  logic [BIT_NUM-1:0]      mul_c10;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [BIT_NUM-1:0]      rsp_c00;
  logic [BIT_NUM-1:0]      rsp_c10;

  modport slave (
`ifdef MULT_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_a00, req_a10, req_b,
    output req_ready,
    output mul_a00, mul_a10, mul_b,
    input  mul_c00, mul_c10,
    output rsp_valid, rsp_id, rsp_c00, rsp_c10,
    input  rsp_ready
  );

  modport master (
`ifdef MULT_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_a00, req_a10, req_b,
    input  req_ready,
    input  mul_a00, mul_a10, mul_b,
    output mul_c00, mul_c10,
    input  rsp_valid, rsp_id, rsp_c00, rsp_c10,
    output rsp_ready
  );
endinterface

// File: rtl/mult_2x1_arb.sv
// Round-robin arbiter sharing one registered 2x1*1x1 fixed-point multiplier among NREQ requesters.
// Latency: grant in cycle N, tagged result at response FIFO head from cycle N+2; one issue/cycle at full rate.
// Backpressure: grants stop while FIFO entries plus the in-flight result would exceed 2 (MULT_ARB_LOCK_EN adds req_lock).
module mult_2x1_arb #(
  parameter int BIT_NUM  = 18,
  parameter int FRAC_NUM = 9,
  parameter int NREQ     = 4,
  parameter int ID_W     = 2
) (
  input logic           clk,
  input logic           rst,
  mult_2x1_arb_if.slave bus
);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BIT_NUM-1:0] c00;
    logic [BIT_NUM-1:0] c10;
  } rsp_t;

  // Parameter sanity; FRAC_NUM only describes the operand format, results pass through untouched.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (ID_W != $clog2(NREQ)) begin : g_bad_idw
    $error("ID_W must equal clog2(NREQ)");
  end
  if (FRAC_NUM < 0 || FRAC_NUM >= BIT_NUM) begin : g_bad_frac
    $error("FRAC_NUM must be in 0..BIT_NUM-1");
  end

  logic [ID_W-1:0] rr_ptr;
  logic            inflight;
  logic [ID_W-1:0] inflight_id;

  rsp_t            mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      cnt;

  logic            pop;
  logic            push;
  logic [2:0]      occupancy;
  logic            space_ok;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] next_ptr;
  logic            issue;

  assign pop       = bus.rsp_valid & bus.rsp_ready;
  assign push      = inflight;
  // A pop this cycle frees a slot for a result issued this cycle (it lands two edges later).
  assign occupancy = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign space_ok  = (occupancy < 3'd2);

  // Find the first valid requester starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // One-hot grant; forced low during reset so nothing transfers while state is being cleared.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && space_ok && gnt_found) bus.req_ready = NREQ'(1) << gnt_id;
  end

  assign issue = |(bus.req_valid & bus.req_ready);

  // Operand mux toward the multiplier; zero when idle so the multiplier inputs are quiet.
  always_comb begin
    bus.mul_a00 = '0;
    bus.mul_a10 = '0;
    bus.mul_b   = '0;
    if (issue) begin
      bus.mul_a00 = bus.req_a00[gnt_id*BIT_NUM +: BIT_NUM];
      bus.mul_a10 = bus.req_a10[gnt_id*BIT_NUM +: BIT_NUM];
      bus.mul_b   = bus.req_b[gnt_id*BIT_NUM +: BIT_NUM];
    end
  end

  // Next search start: one past the winner, or the winner itself when it holds a lock.
  always_comb begin
    next_ptr = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);
`ifdef MULT_ARB_LOCK_EN
    if (bus.req_lock[gnt_id]) next_ptr = gnt_id;
`endif
  end

  // Arbitration pointer and one-deep in-flight tracker matching the multiplier's register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr      <= next_ptr;
        inflight_id <= gnt_id;
      end
    end
  end

  // Two-entry response FIFO; the multiplier result is captured the cycle after its issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {inflight_id, bus.mul_c00, bus.mul_c10};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.rsp_valid = (cnt != 2'd0);
  assign bus.rsp_id    = mem[rd_ptr].id;
  assign bus.rsp_c00   = mem[rd_ptr].c00;
  assign bus.rsp_c10   = mem[rd_ptr].c10;

endmodule
